// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer: address/issue sequencer for an in-place radix-2
// Cooley-Tukey forward NTT driven through one pipelined butterfly.
// Optional feature macro: NTT_SEQ_PERF_CNT_EN enables the busy-cycle
// counter on cycles_o; without it cycles_o is tied to zero.
module ntt_stage_sequencer #(
  parameter int unsigned LOG_N   = 8,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned BF_LAT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     pause_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [$clog2(LOG_N)-1:0] stage_o,
  output logic                     rd_en_o,
  output logic [LOG_N-1:0]         rd_addr_a_o,
  output logic [LOG_N-1:0]         rd_addr_b_o,
  output logic [LOG_N-1:0]         tw_addr_o,
  output logic                     bf_valid_o,
  input  logic                     bf_out_valid_i,
  output logic                     wr_en_o,
  output logic [LOG_N-1:0]         wr_addr_a_o,
  output logic [LOG_N-1:0]         wr_addr_b_o,
  output logic [31:0]              cycles_o
);

  localparam int unsigned SW     = $clog2(LOG_N);
  localparam int unsigned HALF_N = 1 << (LOG_N - 1);
  localparam int unsigned DL     = MEM_LAT + BF_LAT;
  localparam int unsigned IW     = $clog2(DL + 2);

  localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG_N - 1);
  localparam logic [LOG_N-1:0] LAST_B     = LOG_N'(HALF_N - 1);
  localparam logic [DL-1:0]    DL_TOP     = DL'(1) << (DL - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t           state_q;
  logic [LOG_N-1:0] b_q;
  logic [IW-1:0]    inflight_q;
  logic [DL-1:0]    dl_v_q;
  logic [LOG_N-1:0] dl_a_q [DL];
  logic [LOG_N-1:0] dl_b_q [DL];

  logic [SW-1:0]    iss_s_c;
  logic [LOG_N-1:0] iss_b_c;
  logic [LOG_N-1:0] half_c;
  logic [LOG_N-1:0] g_c;
  logic [LOG_N-1:0] o_c;
  logic [LOG_N-1:0] addr_a_c;
  logic [LOG_N-1:0] addr_b_c;
  logic [LOG_N-1:0] tw_c;
  logic             dl_last_c;
  logic             drain_exit_c;

  // Operand addresses for the butterfly about to be issued; the first
  // butterfly of a stage is issued straight out of IDLE or DRAIN.
  always_comb begin
    iss_s_c = stage_o;
    iss_b_c = b_q;
    if (state_q == IDLE) begin
      iss_s_c = '0;
      iss_b_c = '0;
    end else if (state_q == DRAIN) begin
      iss_s_c = stage_o + SW'(1);
      iss_b_c = '0;
    end
    half_c   = LOG_N'(HALF_N) >> iss_s_c;
    g_c      = iss_b_c >> (LAST_STAGE - iss_s_c);
    o_c      = iss_b_c & (half_c - LOG_N'(1));
    addr_a_c = ((g_c << 1) * half_c) + o_c;
    addr_b_c = addr_a_c + half_c;
    tw_c     = (LOG_N'(1) << iss_s_c) + g_c;
  end

  // Stage is finished when the only slot left in flight is writing back now.
  always_comb begin
    dl_last_c    = (dl_v_q == DL_TOP);
    drain_exit_c = (state_q == DRAIN) && !rd_en_o &&
                   ((wr_en_o && (inflight_q == IW'(1))) || dl_last_c);
  end

  assign bf_valid_o  = dl_v_q[MEM_LAT-1];
  assign wr_en_o     = bf_out_valid_i & dl_v_q[DL-1];
  assign wr_addr_a_o = dl_a_q[DL-1];
  assign wr_addr_b_o = dl_b_q[DL-1];

  // Address delay line aligning write-back addresses with butterfly outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_v_q <= '0;
      for (int unsigned i = 0; i < DL; i++) begin
        dl_a_q[i] <= '0;
        dl_b_q[i] <= '0;
      end
    end else begin
      dl_v_q    <= {dl_v_q[DL-2:0], rd_en_o};
      dl_a_q[0] <= rd_addr_a_o;
      dl_b_q[0] <= rd_addr_b_o;
      for (int unsigned i = 1; i < DL; i++) begin
        dl_a_q[i] <= dl_a_q[i-1];
        dl_b_q[i] <= dl_b_q[i-1];
      end
    end
  end

  // Sequencer FSM with issue registers, in-flight tracking and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      stage_o     <= '0;
      b_q         <= '0;
      inflight_q  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_a_o <= '0;
      rd_addr_b_o <= '0;
      tw_addr_o   <= '0;
    end else begin
      rd_en_o <= 1'b0;
      done_o  <= 1'b0;

      if (rd_en_o && !wr_en_o && (inflight_q != '1)) begin
        inflight_q <= inflight_q + IW'(1);
      end else if (!rd_en_o && wr_en_o && (inflight_q != '0)) begin
        inflight_q <= inflight_q - IW'(1);
      end

      if (bf_out_valid_i != dl_v_q[DL-1]) begin
        err_o <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q     <= ISSUE;
            stage_o     <= '0;
            b_q         <= LOG_N'(1);
            busy_o      <= 1'b1;
            err_o       <= 1'b0;
            rd_en_o     <= 1'b1;
            rd_addr_a_o <= addr_a_c;
            rd_addr_b_o <= addr_b_c;
            tw_addr_o   <= tw_c;
          end
        end
        ISSUE: begin
          if (!pause_i) begin
            rd_en_o     <= 1'b1;
            rd_addr_a_o <= addr_a_c;
            rd_addr_b_o <= addr_b_c;
            tw_addr_o   <= tw_c;
            b_q         <= b_q + LOG_N'(1);
            if (b_q == LAST_B) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_exit_c) begin
            inflight_q <= '0;
            if (stage_o == LAST_STAGE) begin
              state_q <= FINISH;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              state_q     <= ISSUE;
              stage_o     <= stage_o + SW'(1);
              b_q         <= LOG_N'(1);
              rd_en_o     <= 1'b1;
              rd_addr_a_o <= addr_a_c;
              rd_addr_b_o <= addr_b_c;
              tw_addr_o   <= tw_c;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef NTT_SEQ_PERF_CNT_EN
  // Busy-cycle counter, cleared on an accepted start, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_o <= '0;
    end else if ((state_q == IDLE) && start_i) begin
      cycles_o <= '0;
    end else if (busy_o && (cycles_o != '1)) begin
      cycles_o <= cycles_o + 32'd1;
    end
  end
`else
  assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench for ntt_stage_sequencer with a 4-cycle butterfly model.
module tb_ntt_stage_sequencer;

  localparam int LOG_N = 8;
  localparam int N     = 256;
  localparam int TOT   = 1024;

`ifdef NTT_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        pause_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [2:0]  stage_o;
  logic        rd_en_o;
  logic [7:0]  rd_addr_a_o;
  logic [7:0]  rd_addr_b_o;
  logic [7:0]  tw_addr_o;
  logic        bf_valid_o;
  logic        bf_out_valid_i;
  logic        wr_en_o;
  logic [7:0]  wr_addr_a_o;
  logic [7:0]  wr_addr_b_o;
  logic [31:0] cycles_o;
  logic        kill;

  int checks = 0;
  int errors = 0;

  ntt_stage_sequencer #(.LOG_N(8), .MEM_LAT(1), .BF_LAT(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pause_i(pause_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .stage_o(stage_o),
    .rd_en_o(rd_en_o), .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o),
    .tw_addr_o(tw_addr_o), .bf_valid_o(bf_valid_o),
    .bf_out_valid_i(bf_out_valid_i), .wr_en_o(wr_en_o),
    .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o), .cycles_o(cycles_o)
  );

  always #5 clk = ~clk;

  // Butterfly model: in_valid -> out_valid after 4 cycles; kill drops an output.
  logic [3:0] bf_pipe;
  always @(posedge clk or posedge rst) begin
    if (rst) bf_pipe <= '0;
    else     bf_pipe <= {bf_pipe[2:0], bf_valid_o};
  end
  assign bf_out_valid_i = bf_pipe[3] & ~kill;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference schedule from the textbook CT loop nest.
  logic [7:0] ea [TOT];
  logic [7:0] eb [TOT];
  logic [7:0] et [TOT];
  logic [2:0] es [TOT];

  // Monitor: logs every read/write of the current run against the schedule.
  logic       busy_last = 1'b0;
  int         rd_idx = 0, wr_idx = 0, rise_cyc = 0, busy_cnt = 0;
  int         rd_total = 0, wr_total = 0, done_cnt = 0;
  int         addr_bad = 0, wr_bad = 0;
  logic [7:0] la [TOT];
  logic [7:0] lb [TOT];
  logic [7:0] lt [TOT];
  int         rd_rel [TOT];
  logic       rise_c;
  int         ri_c, wi_c;
  assign rise_c = busy_o && !busy_last;
  assign ri_c   = rise_c ? 0 : rd_idx;
  assign wi_c   = rise_c ? 0 : wr_idx;

  always @(negedge clk) begin
    busy_last <= busy_o;
    if (rise_c) begin
      rise_cyc <= cyc;
      busy_cnt <= 1;
    end else if (busy_o) begin
      busy_cnt <= busy_cnt + 1;
    end
    if (rd_en_o) begin
      rd_total <= rd_total + 1;
      rd_idx   <= ri_c + 1;
      if (ri_c < TOT) begin
        la[ri_c]     <= rd_addr_a_o;
        lb[ri_c]     <= rd_addr_b_o;
        lt[ri_c]     <= tw_addr_o;
        rd_rel[ri_c] <= rise_c ? 1 : cyc - rise_cyc + 1;
        if (rd_addr_a_o !== ea[ri_c] || rd_addr_b_o !== eb[ri_c] ||
            tw_addr_o !== et[ri_c] || stage_o !== es[ri_c])
          addr_bad <= addr_bad + 1;
      end else begin
        addr_bad <= addr_bad + 1;
      end
    end else if (rise_c) begin
      rd_idx <= 0;
    end
    if (wr_en_o) begin
      wr_total <= wr_total + 1;
      wr_idx   <= wi_c + 1;
      if (wi_c >= TOT || wr_addr_a_o !== ea[wi_c] || wr_addr_b_o !== eb[wi_c])
        wr_bad <= wr_bad + 1;
    end else if (rise_c) begin
      wr_idx <= 0;
    end
    if (done_o) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One transform: start in relative cycle 0, optional pause/extra start/kill/reset.
  task automatic run_xfer(input int pause_at, input int pause_len, input int start_at,
                          input int kill_at, input int rst_at,
                          output bit got_done, output int done_r, output logic err1);
    got_done = 1'b0;
    done_r   = -1;
    err1     = 1'bx;
    @(posedge clk); #1;
    for (int r = 0; r < 1300; r++) begin
      start_i = (r == 0) || (r == start_at);
      pause_i = (r >= pause_at) && (r < pause_at + pause_len);
      kill    = (r == kill_at);
      if (r == rst_at) begin
        rst = 1'b1; start_i = 1'b0; pause_i = 1'b0; kill = 1'b0;
        return;
      end
      @(negedge clk);
      if (r == 1) err1 = err_o;
      if (done_o) begin
        got_done = 1'b1;
        done_r   = r;
        break;
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0; pause_i = 1'b0; kill = 1'b0;
  endtask

  initial begin
    bit   gd;
    int   dr, k, rd0, wr0, ab0, wb0, dc0;
    logic e1;

    k = 0;
    for (int s = 0; s < LOG_N; s++) begin
      int len;
      len = N >> (s + 1);
      for (int grp = 0; grp < (1 << s); grp++)
        for (int j = 0; j < len; j++) begin
          ea[k] = 8'(grp * 2 * len + j);
          eb[k] = 8'(grp * 2 * len + j + len);
          et[k] = 8'((1 << s) + grp);
          es[k] = 3'(s);
          k++;
        end
    end

    rst = 1'b1; start_i = 1'b0; pause_i = 1'b0; kill = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst.busy", busy_o, 0);
    chk("rst.done", done_o, 0);
    chk("rst.err", err_o, 0);
    chk("rst.rd_en", rd_en_o, 0);
    chk("rst.wr_en", wr_en_o, 0);
    chk("rst.stage", stage_o, 0);
    chk("rst.cycles", cycles_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Run A: plain transform with a stray start pulse while busy.
    rd0 = rd_total; wr0 = wr_total; ab0 = addr_bad; wb0 = wr_bad; dc0 = done_cnt;
    run_xfer(-1, 0, 300, -1, -1, gd, dr, e1);
    chk("A.done_seen", gd, 1);
    chk("A.done_cycle", dr, 1065);
    chk("A.busy_at_done", busy_o, 0);
    repeat (5) @(negedge clk);
    chk("A.done_pulses", done_cnt - dc0, 1);
    chk("A.reads", rd_total - rd0, TOT);
    chk("A.writes", wr_total - wr0, TOT);
    chk("A.busy_cycles", busy_cnt, 1064);
    chk("A.cycles", cycles_o, PERF ? 64'd1064 : 64'd0);
    chk("A.err", err_o, 0);
    chk("A.rd_sched", addr_bad - ab0, 0);
    chk("A.wr_sched", wr_bad - wb0, 0);
    chk("A.s0b0.a", la[0], 0);
    chk("A.s0b0.b", lb[0], 128);
    chk("A.s0b0.tw", lt[0], 1);
    chk("A.s0b127.a", la[127], 127);
    chk("A.s0b127.b", lb[127], 255);
    chk("A.s0b127.tw", lt[127], 1);
    chk("A.s7b5.a", la[7*128+5], 10);
    chk("A.s7b5.b", lb[7*128+5], 11);
    chk("A.s7b5.tw", lt[7*128+5], 133);
    chk("A.first_rd_cycle", rd_rel[0], 1);
    chk("A.s1_first_rd", rd_rel[128], 134);
    chk("A.last_rd", rd_rel[1023], 1059);

    // Run B: ten paused cycles in the middle of stage 3.
    rd0 = rd_total; ab0 = addr_bad; wb0 = wr_bad;
    run_xfer(450, 10, -1, -1, -1, gd, dr, e1);
    chk("B.done_seen", gd, 1);
    chk("B.done_cycle", dr, 1075);
    repeat (5) @(negedge clk);
    chk("B.reads", rd_total - rd0, TOT);
    chk("B.rd_sched", addr_bad - ab0, 0);
    chk("B.wr_sched", wr_bad - wb0, 0);
    chk("B.s3b50_rd", rd_rel[384+50], 450);
    chk("B.s3b51_rd", rd_rel[384+51], 461);
    chk("B.last_rd", rd_rel[1023], 1069);
    chk("B.cycles", cycles_o, PERF ? 64'd1074 : 64'd0);
    chk("B.err", err_o, 0);

    // Run C: one butterfly output dropped -> sticky error.
    wr0 = wr_total;
    run_xfer(-1, 0, -1, 200, -1, gd, dr, e1);
    chk("C.done_seen", gd, 1);
    chk("C.done_cycle", dr, 1065);
    chk("C.err_sticky", err_o, 1);
    repeat (5) @(negedge clk);
    chk("C.writes", wr_total - wr0, TOT - 1);
    chk("C.err_idle", err_o, 1);

    // Run D: new start clears the error; reset lands in cycle 500.
    run_xfer(-1, 0, -1, -1, 500, gd, dr, e1);
    chk("D.err_cleared", e1, 0);
    #1;
    chk("D.rst.busy", busy_o, 0);
    chk("D.rst.rd_en", rd_en_o, 0);
    chk("D.rst.wr_en", wr_en_o, 0);
    chk("D.rst.bf_valid", bf_valid_o, 0);
    chk("D.rst.stage", stage_o, 0);
    chk("D.rst.rd_addr_a", rd_addr_a_o, 0);
    chk("D.rst.wr_addr_a", wr_addr_a_o, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    rd0 = rd_total; wr0 = wr_total;
    repeat (10) @(negedge clk);
    chk("D.post_rst_writes", wr_total - wr0, 0);
    chk("D.post_rst_reads", rd_total - rd0, 0);
    chk("D.post_rst_busy", busy_o, 0);

    // Run E: clean transform after the aborted one.
    rd0 = rd_total; wr0 = wr_total; ab0 = addr_bad; wb0 = wr_bad;
    run_xfer(-1, 0, -1, -1, -1, gd, dr, e1);
    chk("E.done_seen", gd, 1);
    chk("E.done_cycle", dr, 1065);
    repeat (5) @(negedge clk);
    chk("E.reads", rd_total - rd0, TOT);
    chk("E.writes", wr_total - wr0, TOT);
    chk("E.rd_sched", addr_bad - ab0, 0);
    chk("E.wr_sched", wr_bad - wb0, 0);
    chk("E.err", err_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
